// File: rtl/hash_job_scheduler.sv
// hash_job_scheduler
//   Dispatches nonces to NUM_CORES hash cores in round-robin order, collects
//   their bit-distance scores, tracks the best (lowest) score seen and reports
//   every improvement over a valid/ready channel.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   enable_i             level-sensitive dispatch permission
//   base_load_i          load base_nonce_i into the nonce counter (only when
//   base_nonce_i         idle: busy_o=0 and enable_i=0)
//   core_start_o         one-hot single-cycle start strobe per core
//   core_nonce_o         nonce for the strobed core (0 when no strobe)
//   core_done_i          per-core single-cycle completion strobes
//   core_score_i         per-core scores, core k at [k*SCORE_W +: SCORE_W]
//   report_valid_o       improvement report handshake
//   report_ready_i
//   report_score_o       reported score / nonce, held while stalled
//   report_nonce_o
//   busy_o               high while any core is running
module hash_job_scheduler #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned NONCE_W   = 256,
    parameter int unsigned SCORE_W   = 11
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         enable_i,
    input  logic                         base_load_i,
    input  logic [NONCE_W-1:0]           base_nonce_i,
    output logic [NUM_CORES-1:0]         core_start_o,
    output logic [NONCE_W-1:0]           core_nonce_o,
    input  logic [NUM_CORES-1:0]         core_done_i,
    input  logic [NUM_CORES*SCORE_W-1:0] core_score_i,
    output logic                         report_valid_o,
    input  logic                         report_ready_i,
    output logic [SCORE_W-1:0]           report_score_o,
    output logic [NONCE_W-1:0]           report_nonce_o,
    output logic                         busy_o
);

    localparam int unsigned IDX_W = $clog2(NUM_CORES);

    typedef enum logic {IDLE, RUN} state_e;

    state_e               state_q, state_d;
    logic [NUM_CORES-1:0] busy_q, busy_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [NONCE_W-1:0]   cnt_q, cnt_d;
    logic [NONCE_W-1:0]   tag_q [NUM_CORES];
    logic [NONCE_W-1:0]   tag_d [NUM_CORES];
    logic [SCORE_W-1:0]   best_score_q, best_score_d;
    logic [NONCE_W-1:0]   best_nonce_q, best_nonce_d;
    logic                 dirty_q, dirty_d;
    logic                 rep_valid_q, rep_valid_d;
    logic [SCORE_W-1:0]   rep_score_q, rep_score_d;
    logic [NONCE_W-1:0]   rep_nonce_q, rep_nonce_d;

    logic                 found_hi, found_lo, start_ok;
    logic [IDX_W-1:0]     idx_hi, idx_lo, start_idx;
    logic [NUM_CORES-1:0] start_vec, accept;
    logic                 cand_valid, improve, load_rep;
    logic [SCORE_W-1:0]   cand_score;
    logic [NONCE_W-1:0]   cand_nonce;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (enable_i) state_d = RUN;
            RUN:     if (!enable_i && busy_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Round-robin pick: first free core at or above the pointer, otherwise
    // wrap around to the lowest free core.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            if (!busy_q[k] && !found_hi && IDX_W'(k) >= ptr_q) begin
                found_hi = 1'b1;
                idx_hi   = IDX_W'(k);
            end
            if (!busy_q[k] && !found_lo) begin
                found_lo = 1'b1;
                idx_lo   = IDX_W'(k);
            end
        end
        start_ok  = (state_q == RUN) && enable_i && found_lo;
        start_idx = found_hi ? idx_hi : idx_lo;
        start_vec = '0;
        if (start_ok) start_vec[start_idx] = 1'b1;
    end

    // Minimum score among accepted completions; strict '<' keeps the lowest
    // index on ties.
    always_comb begin
        accept     = core_done_i & busy_q;
        cand_valid = 1'b0;
        cand_score = '1;
        cand_nonce = '0;
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            if (accept[k] && (!cand_valid || core_score_i[k*SCORE_W +: SCORE_W] < cand_score)) begin
                cand_valid = 1'b1;
                cand_score = core_score_i[k*SCORE_W +: SCORE_W];
                cand_nonce = tag_q[k];
            end
        end
        improve = cand_valid && (cand_score < best_score_q);
    end

    always_comb begin
        busy_d = (busy_q & ~accept) | start_vec;
        tag_d  = tag_q;
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        if (start_ok) begin
            tag_d[start_idx] = cnt_q;
            cnt_d            = cnt_q + 1'b1;
            ptr_d            = (start_idx == IDX_W'(NUM_CORES - 1)) ? '0 : start_idx + 1'b1;
        end else if (base_load_i && !busy_o && !enable_i) begin
            cnt_d = base_nonce_i;
        end
    end

    // dirty_q marks a best value not yet copied into the report registers; an
    // improvement landing on the same edge as a load keeps it set so the newer
    // value follows in the next report.
    always_comb begin
        best_score_d = best_score_q;
        best_nonce_d = best_nonce_q;
        rep_valid_d  = rep_valid_q;
        rep_score_d  = rep_score_q;
        rep_nonce_d  = rep_nonce_q;
        load_rep     = dirty_q && (!rep_valid_q || report_ready_i);
        if (load_rep) begin
            rep_valid_d = 1'b1;
            rep_score_d = best_score_q;
            rep_nonce_d = best_nonce_q;
        end else if (rep_valid_q && report_ready_i) begin
            rep_valid_d = 1'b0;
        end
        if (improve) begin
            best_score_d = cand_score;
            best_nonce_d = cand_nonce;
        end
        dirty_d = (dirty_q && !load_rep) || improve;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            busy_q       <= '0;
            ptr_q        <= '0;
            cnt_q        <= '0;
            for (int unsigned k = 0; k < NUM_CORES; k++) tag_q[k] <= '0;
            best_score_q <= '1;
            best_nonce_q <= '0;
            dirty_q      <= 1'b0;
            rep_valid_q  <= 1'b0;
            rep_score_q  <= '0;
            rep_nonce_q  <= '0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            tag_q        <= tag_d;
            best_score_q <= best_score_d;
            best_nonce_q <= best_nonce_d;
            dirty_q      <= dirty_d;
            rep_valid_q  <= rep_valid_d;
            rep_score_q  <= rep_score_d;
            rep_nonce_q  <= rep_nonce_d;
        end
    end

    assign core_start_o   = start_vec;
    assign core_nonce_o   = start_ok ? cnt_q : '0;
    assign busy_o         = |busy_q;
    assign report_valid_o = rep_valid_q;
    assign report_score_o = rep_score_q;
    assign report_nonce_o = rep_nonce_q;

endmodule

// File: tb/tb_hash_job_scheduler.sv
// tb_hash_job_scheduler
//   Directed scenarios followed by randomized traffic, all outputs compared
//   every cycle against a behavioural model of the scheduling rules.
module tb_hash_job_scheduler;

    localparam int N  = 4;
    localparam int NW = 256;
    localparam int SW = 11;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            enable = 1'b0;
    logic            base_load = 1'b0;
    logic [NW-1:0]   base_nonce = '0;
    logic [N-1:0]    core_start;
    logic [NW-1:0]   core_nonce;
    logic [N-1:0]    core_done = '0;
    logic [N*SW-1:0] core_score = '0;
    logic            rep_valid;
    logic            rep_ready = 1'b0;
    logic [SW-1:0]   rep_score;
    logic [NW-1:0]   rep_nonce;
    logic            busy;

    int checks = 0;
    int errors = 0;

    hash_job_scheduler #(.NUM_CORES(N), .NONCE_W(NW), .SCORE_W(SW)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .enable_i       (enable),
        .base_load_i    (base_load),
        .base_nonce_i   (base_nonce),
        .core_start_o   (core_start),
        .core_nonce_o   (core_nonce),
        .core_done_i    (core_done),
        .core_score_i   (core_score),
        .report_valid_o (rep_valid),
        .report_ready_i (rep_ready),
        .report_score_o (rep_score),
        .report_nonce_o (rep_nonce),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    // Behavioural model
    bit            m_run;
    bit            m_busy [N];
    logic [NW-1:0] m_tag  [N];
    int            m_ptr;
    logic [NW-1:0] m_cnt;
    logic [SW-1:0] m_best;
    logic [NW-1:0] m_best_n;
    bit            m_rv;
    logic [SW-1:0] m_rs;
    logic [NW-1:0] m_rn;
    bit            m_new;
    // Emulated core latencies (-1 = no job pending completion)
    bit            auto_mode = 1'b0;
    int            lat    [N];
    logic [SW-1:0] lat_sc [N];

    task automatic chk(input string tag, input logic [NW-1:0] obs, input logic [NW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_run = 0; m_ptr = 0; m_cnt = '0;
        m_best = '1; m_best_n = '0;
        m_rv = 0; m_rs = '0; m_rn = '0; m_new = 0;
        for (int k = 0; k < N; k++) begin
            m_busy[k] = 0; m_tag[k] = '0; lat[k] = -1; lat_sc[k] = '0;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_start"}, core_start, '0);
        chk({tag, "_nonce"}, core_nonce, '0);
        chk({tag, "_busy"}, busy, '0);
        chk({tag, "_rvalid"}, rep_valid, '0);
        chk({tag, "_rscore"}, rep_score, '0);
        chk({tag, "_rnonce"}, rep_nonce, '0);
    endtask

    // Called 1 time unit after an active edge with this cycle's inputs driven.
    task automatic step();
        int            tgt;
        bit            anyb, cf;
        logic [SW-1:0] cs;
        logic [NW-1:0] cn;
        #1;
        tgt = -1;
        anyb = 0;
        for (int k = 0; k < N; k++) anyb |= m_busy[k];
        if (m_run && enable)
            for (int o = 0; o < N; o++)
                if (tgt < 0 && !m_busy[(m_ptr + o) % N]) tgt = (m_ptr + o) % N;
        chk("start", core_start, (tgt >= 0) ? (256'(1) << tgt) : '0);
        chk("nonce", core_nonce, (tgt >= 0) ? m_cnt : '0);
        chk("busy", busy, anyb);
        chk("rep_valid", rep_valid, m_rv);
        chk("rep_score", rep_score, m_rs);
        chk("rep_nonce", rep_nonce, m_rn);
        cf = 0; cs = '1; cn = '0;
        for (int k = 0; k < N; k++)
            if (core_done[k] && m_busy[k] && (!cf || core_score[k*SW +: SW] < cs)) begin
                cf = 1; cs = core_score[k*SW +: SW]; cn = m_tag[k];
            end
        if (m_new && (!m_rv || rep_ready)) begin
            m_rv = 1; m_rs = m_best; m_rn = m_best_n; m_new = 0;
        end else if (m_rv && rep_ready) begin
            m_rv = 0;
        end
        if (cf && cs < m_best) begin
            m_best = cs; m_best_n = cn; m_new = 1;
        end
        for (int k = 0; k < N; k++) if (core_done[k]) m_busy[k] = 0;
        if (tgt >= 0) begin
            m_busy[tgt] = 1;
            m_tag[tgt]  = m_cnt;
            m_cnt       = m_cnt + 1'b1;
            m_ptr       = (tgt + 1) % N;
            if (auto_mode) begin
                lat[tgt]    = $urandom_range(1, 5);
                lat_sc[tgt] = SW'($urandom_range(0, 2047));
            end
        end else if (base_load && !anyb && !enable) begin
            m_cnt = base_nonce;
        end
        if (!m_run && enable) m_run = 1;
        else if (m_run && !enable && !anyb) m_run = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cores();
        core_done = '0;
        for (int k = 0; k < N; k++) begin
            if (lat[k] > 0) begin
                lat[k]--;
                if (lat[k] == 0) begin
                    core_done[k] = 1'b1;
                    core_score[k*SW +: SW] = lat_sc[k];
                    lat[k] = -1;
                end
            end else if (!m_busy[k] && $urandom_range(0, 7) == 0) begin
                core_done[k] = 1'b1;   // spurious strobe on an idle core
                core_score[k*SW +: SW] = SW'($urandom_range(0, 2047));
            end
        end
    endtask

    // Asynchronous reset pulse, then stale done strobes from the lost jobs.
    task automatic reset_mid(input string tag);
        logic [N-1:0] stale;
        stale = '0;
        for (int k = 0; k < N; k++) stale[k] = m_busy[k];
        #1;
        rst_n = 1'b0;
        #2;
        chk_reset_outputs(tag);
        m_reset();
        core_done = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        core_done = stale | 4'b0001;
        core_score = '0;
        step();
        core_done = '0;
        #1;
        chk({tag, "_stale_ignored"}, rep_valid, '0);
        step();
        #1;
        chk({tag, "_stale_ignored2"}, rep_valid, '0);
    endtask

    initial begin
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // Base load then four consecutive starts
        base_nonce = 256'h10;
        base_load = 1'b1;
        step();
        base_load = 1'b0;
        enable = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("seq_start", core_start, 256'(1) << i);
            chk("seq_nonce", core_nonce, 256'h10 + 256'(i));
            step();
        end

        // Tie between cores 1 and 2 resolves to core 1
        core_done = 4'b0110;
        core_score[1*SW +: SW] = 11'd400;
        core_score[2*SW +: SW] = 11'd400;
        step();
        core_done = '0;
        enable = 1'b0;
        step();
        #1;
        chk("tie_valid", rep_valid, 1);
        chk("tie_score", rep_score, 400);
        chk("tie_nonce", rep_nonce, 256'h11);
        rep_ready = 1'b1;
        step();
        rep_ready = 1'b0;
        step();
        #1;
        chk("tie_single_report", rep_valid, 0);

        // Drain with enable low; loads while busy are ignored
        chk("drain_busy", busy, 1);
        base_load = 1'b1;
        base_nonce = 256'h55;
        core_done = 4'b0001;
        core_score[0 +: SW] = 11'd900;
        step();
        base_load = 1'b0;
        core_done = '0;
        step();
        #1;
        chk("drain_still_busy", busy, 1);
        chk("drain_no_start", core_start, '0);
        core_done = 4'b1000;
        core_score[3*SW +: SW] = 11'd100;
        step();
        core_done = '0;
        #1;
        chk("drain_idle", busy, 0);

        // Counter wrap
        base_nonce = '1;
        base_load = 1'b1;
        step();
        base_load = 1'b0;
        enable = 1'b1;
        step();
        #1;
        chk("wrap_ones", core_nonce, '1);
        step();
        #1;
        chk("wrap_zero", core_nonce, '0);
        step();
        enable = 1'b0;
        core_done = 4'b0011;
        core_score[0 +: SW] = 11'd2047;
        core_score[1*SW +: SW] = 11'd2047;
        rep_ready = 1'b1;
        step();
        core_done = '0;
        repeat (3) step();
        rep_ready = 1'b0;

        // Report held under backpressure
        reset_mid("rst1");
        enable = 1'b1;
        repeat (3) step();
        enable = 1'b0;
        core_done = 4'b0001;
        core_score[0 +: SW] = 11'd500;
        step();
        core_done = '0;
        step();
        #1;
        chk("hold_valid", rep_valid, 1);
        chk("hold_first", rep_score, 500);
        core_done = 4'b0010;
        core_score[1*SW +: SW] = 11'd300;
        step();
        core_done = '0;
        step();
        #1;
        chk("hold_score", rep_score, 500);
        chk("hold_nonce", rep_nonce, '0);
        rep_ready = 1'b1;
        step();
        rep_ready = 1'b0;
        #1;
        chk("next_valid", rep_valid, 1);
        chk("next_score", rep_score, 300);
        chk("next_nonce", rep_nonce, 256'h1);
        rep_ready = 1'b1;
        step();
        rep_ready = 1'b0;
        step();
        #1;
        chk("next_dropped", rep_valid, 0);

        // Randomized traffic with periodic mid-run resets
        auto_mode = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (c % 100 == 50) reset_mid("rst_rand");
            enable     = (c % 100 < 85) ? ($urandom_range(0, 9) != 0) : 1'b0;
            rep_ready  = 1'($urandom_range(0, 1));
            base_load  = ($urandom_range(0, 5) == 0);
            base_nonce = {$urandom, $urandom, $urandom, $urandom,
                          $urandom, $urandom, $urandom, $urandom};
            drive_cores();
            step();
        end
        enable = 1'b0;
        base_load = 1'b0;
        rep_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            drive_cores();
            step();
        end
        #1;
        chk("final_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hash_job_scheduler.md
HASH_JOB_SCHEDULER -- requirements
Module: hash_job_scheduler

Interface
REQ-001 The module SHALL have parameter NUM_CORES, default 4, meaning the number of hash cores scheduled (2..8).
REQ-002 The module SHALL have parameter NONCE_W, default 256, meaning the nonce width in bits.
REQ-003 The module SHALL have parameter SCORE_W, default 11, meaning the bit-distance score width (0..1024 fits).
REQ-004 The module SHALL have port clk_i  input  1  system clock; all state changes on its rising edge.
REQ-005 The module SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 The module SHALL have port enable_i  input  1  dispatch permission; level-sensitive.
REQ-007 The module SHALL have port base_load_i  input  1  load request for the nonce counter.
REQ-008 The module SHALL have port base_nonce_i  input  NONCE_W  starting nonce value.
REQ-009 The module SHALL have port core_start_o  output  NUM_CORES  one-hot single-cycle start strobe, one bit per core.
REQ-010 The module SHALL have port core_nonce_o  output  NONCE_W  nonce for the strobed core; valid only while core_start_o is nonzero.
REQ-011 The module SHALL have port core_done_i  input  NUM_CORES  single-cycle completion strobes.
REQ-012 The module SHALL have port core_score_i  input  NUM_CORES*SCORE_W  per-core score, core k at bits [k*SCORE_W +: SCORE_W]; sampled with done.
REQ-013 The module SHALL have port report_valid_o / report_ready_i  output/input  1/1  valid-ready handshake for improvement reports.
REQ-014 The module SHALL have port report_score_o  output  SCORE_W  reported score.
REQ-015 The module SHALL have port report_nonce_o  output  NONCE_W  reported nonce.
REQ-016 The module SHALL have port busy_o  output  1  high while any core is running.

Function
REQ-017 Per-core busy bit and nonce tag register SHALL exist: the busy bit is set in the start cycle and cleared in the cycle after the core's done strobe is sampled.
REQ-018 The FSM SHALL have states IDLE and RUN: IDLE->RUN when enable_i=1; RUN->IDLE when enable_i=0 and no core busy.
REQ-019 In RUN with enable_i=1, the scheduler SHALL issue at most one start per cycle, to the first non-busy core at or after the round-robin pointer, wrapping modulo NUM_CORES.
REQ-020 On each start, the scheduler SHALL drive core_nonce_o with the counter value, tag the core with that value, increment the counter modulo 2^NONCE_W (silent wrap), and set the pointer to the started index +1.
REQ-021 When enable_i=0, no new starts SHALL be issued; outstanding cores still complete and are scored.
REQ-022 A core whose done is sampled in cycle t SHALL NOT be restarted before cycle t+1.
REQ-023 base_load_i SHALL load the counter only when busy_o=0 and enable_i=0; otherwise it is ignored.
REQ-024 Multiple done strobes in one cycle SHALL all be accepted: the candidate is the minimum score, with ties resolved to the lowest core index.
REQ-025 A done strobe on a non-busy core SHALL be ignored.
REQ-026 The best_score/best_nonce registers SHALL update only when candidate < best_score, strictly less.
REQ-027 The report registers SHALL load from best and raise report_valid_o one cycle after an update, when no report is pending.
REQ-028 report_score_o and report_nonce_o SHALL be stable while report_valid_o=1 and report_ready_i=0; improvements in that window update only the best registers.
REQ-029 On handshake completion, if best differs from the reported value, the next report SHALL be raised the following cycle; otherwise report_valid_o drops.

Reset
REQ-030 While rst_ni=0, the block SHALL hold FSM=IDLE, all busy bits=0, pointer=0, counter=0, tags=0, best_score=all-ones, best_nonce=0, report_valid_o=0, report data=0, core_start_o=0, core_nonce_o=0, and busy_o=0.
REQ-031 Reset asserted mid-run SHALL discard outstanding jobs; done strobes from cores after release SHALL be ignored per REQ-025.

Verification
REQ-032 Load base 0x10 with enable_i=0, then enable_i=1 with all cores idle -> starts to cores 0,1,2,3 on consecutive cycles with nonces 0x10..0x13.
REQ-033 Cores 1 and 2 are done in the same cycle with scores 400 and 400, best=2047 -> best=400 with core 1's nonce, and one report is issued.
REQ-034 A report is pending (score 500) with ready low, and score 300 then arrives -> report holds 500 until ready; the next cycle raises a report with 300.
REQ-035 Counter at 2^NONCE_W-1 -> the next start nonce is all-ones, and the following start is 0.
REQ-036 enable_i drops with 2 cores busy -> no new starts, both dones scored, and busy_o falls after the last one; then base_load_i succeeds.
REQ-037 rst_ni is pulsed low mid-run -> all outputs are at reset values, and a stale core_done_i after release causes no update.
